mm_job_sequencer: RTL

Sequencer that drives the 3x3 fused matrix-multiply PCPI coprocessor as a PCPI master, with no CPU in the loop. It accepts a job descriptor (base address), fetches 28 16-bit operands (A, B, bias, threshold) from a local memory read port, and issues them as custom-0 load instructions. It then issues start, waits for completion, and issues clear. It sits between a job queue/DMA front end and the matrix unit's PCPI slave port.

---
 rtl/mm_job_sequencer.sv | 163 ++++++++++++++++
 1 files changed

// File: rtl/mm_job_sequencer.sv
// Drives a 3x3 matrix-multiply PCPI coprocessor: fetches 28 operands, then loads, starts, waits and clears.
// Optional macro MM_SEQ_TIMEOUT_EN adds a compute-wait watchdog that aborts with an err pulse.
module mm_job_sequencer #(
  parameter int ADDR_W  = 16,
  parameter int TIMEOUT = 64
) (
  input  logic              clk,
  input  logic              resetn,
  input  logic              job_valid,
  input  logic [ADDR_W-1:0] job_base,
  output logic              job_ready,
  output logic              mem_req,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic              mem_rvalid,
  input  logic [15:0]       mem_rdata,
  output logic              pcpi_valid,
  output logic [31:0]       pcpi_insn,
  input  logic              pcpi_ready,
  input  logic              pcpi_wait,
  output logic              busy,
  output logic              done,
  output logic              err
);

  typedef enum logic [3:0] {
    S_IDLE, S_FETCH, S_RDWAIT, S_LOAD, S_START, S_WBUSY, S_WDONE, S_CLEAR, S_DONE
  } state_t;

  localparam logic [6:0]  OPCODE     = 7'b0001011;
  localparam logic [4:0]  LAST_IDX   = 5'd27;
  localparam logic [31:0] INSN_START = {1'b0, 16'd0, 3'b111, 5'd0, OPCODE};
  localparam logic [31:0] INSN_CLEAR = {1'b0, 16'd0, 3'b101, 5'd0, OPCODE};

  state_t            state;
  logic [4:0]        idx;
  logic [ADDR_W-1:0] base_q;

`ifdef MM_SEQ_TIMEOUT_EN
  localparam int CW = $clog2(TIMEOUT + 1);
  localparam logic [CW-1:0] TMO_LAST = CW'(TIMEOUT - 1);
  logic [CW-1:0] tmo_cnt;
  logic          timed_out;
`else
  assign err = 1'b0;
`endif

  // Outputs are registered and set on the transition into the state that owns them.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      state      <= S_IDLE;
      idx        <= '0;
      base_q     <= '0;
      job_ready  <= 1'b0;
      busy       <= 1'b0;
      mem_req    <= 1'b0;
      mem_addr   <= '0;
      pcpi_valid <= 1'b0;
      pcpi_insn  <= '0;
      done       <= 1'b0;
`ifdef MM_SEQ_TIMEOUT_EN
      err        <= 1'b0;
      tmo_cnt    <= '0;
      timed_out  <= 1'b0;
`endif
    end else begin
      mem_req    <= 1'b0;
      pcpi_valid <= 1'b0;
      pcpi_insn  <= '0;
      done       <= 1'b0;
`ifdef MM_SEQ_TIMEOUT_EN
      err        <= 1'b0;
`endif
      case (state)
        S_IDLE: begin
          job_ready <= 1'b1;
          busy      <= 1'b0;
          if (job_valid && job_ready) begin
            base_q    <= job_base;
            idx       <= '0;
            mem_req   <= 1'b1;
            mem_addr  <= job_base;
            job_ready <= 1'b0;
            busy      <= 1'b1;
            state     <= S_FETCH;
          end
        end
        S_FETCH: state <= S_RDWAIT;
        S_RDWAIT: begin
          if (mem_rvalid) begin
            pcpi_valid <= 1'b1;
            pcpi_insn  <= {1'b0, mem_rdata, 3'b000, idx, OPCODE};
            state      <= S_LOAD;
          end
        end
        S_LOAD: begin
          if (idx == LAST_IDX) begin
            pcpi_valid <= 1'b1;
            pcpi_insn  <= INSN_START;
            state      <= S_START;
          end else begin
            idx      <= idx + 5'd1;
            mem_req  <= 1'b1;
            mem_addr <= base_q + ADDR_W'(idx + 5'd1);
            state    <= S_FETCH;
          end
        end
        S_START: begin
          state <= S_WBUSY;
`ifdef MM_SEQ_TIMEOUT_EN
          tmo_cnt   <= '0;
          timed_out <= 1'b0;
`endif
        end
        S_WBUSY: begin
          if (pcpi_wait) state <= S_WDONE;
`ifdef MM_SEQ_TIMEOUT_EN
          if (tmo_cnt == TMO_LAST) begin
            timed_out  <= 1'b1;
            pcpi_valid <= 1'b1;
            pcpi_insn  <= INSN_CLEAR;
            state      <= S_CLEAR;
          end else begin
            tmo_cnt <= tmo_cnt + 1'b1;
          end
`endif
        end
        S_WDONE: begin
          if (pcpi_ready && !pcpi_wait) begin
            pcpi_valid <= 1'b1;
            pcpi_insn  <= INSN_CLEAR;
            state      <= S_CLEAR;
          end
`ifdef MM_SEQ_TIMEOUT_EN
          else if (tmo_cnt == TMO_LAST) begin
            timed_out  <= 1'b1;
            pcpi_valid <= 1'b1;
            pcpi_insn  <= INSN_CLEAR;
            state      <= S_CLEAR;
          end else begin
            tmo_cnt <= tmo_cnt + 1'b1;
          end
`endif
        end
        S_CLEAR: begin
          state <= S_DONE;
`ifdef MM_SEQ_TIMEOUT_EN
          if (timed_out) err  <= 1'b1;
          else           done <= 1'b1;
`else
          done <= 1'b1;
`endif
        end
        S_DONE: begin
          state     <= S_IDLE;
          job_ready <= 1'b1;
          busy      <= 1'b0;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule
